// File: rtl/hadamard_align_sched.sv
// Schedules a shared 2-lane mantissa alignment shifter over two passes so a
// radix-4 Hadamard stage can align four small-float operands to a common exponent.
module hadamard_align_sched #(
  parameter int unsigned expWidth   = 3,
  parameter int unsigned sigWidth   = 3,
  parameter int unsigned low_expand = 2,
  localparam int unsigned W         = sigWidth + 4 + low_expand
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_sign,
  input  logic [4*expWidth-1:0]    in_exp,
  input  logic [4*sigWidth-1:0]    in_man,
  output logic [2*expWidth-1:0]    sh_exp_offset,
  output logic [2*sigWidth-1:0]    sh_mantissa,
  output logic [2:0]               sh_sign,
  input  logic [2*W-1:0]           sh_man_off,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [expWidth-1:0]      out_exp,
  output logic [4*W-1:0]           out_man
);

  typedef enum logic [1:0] {StIdle, StPass0, StPass1, StOut} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              sign_q;
  logic [4*sigWidth-1:0]   man_q;
  logic [4*expWidth-1:0]   off_q, off_c;
  logic [expWidth-1:0]     emax_q, emax_c;
  logic [4*W-1:0]          slot_q;
  logic                    accept;

  // Offsets are emax - exp, never negative, so they always fit in expWidth bits.
  always_comb begin : find_max
    emax_c = '0;
    off_c  = '0;
    for (int i = 0; i < 4; i++) begin
      if (in_exp[expWidth*i +: expWidth] > emax_c) emax_c = in_exp[expWidth*i +: expWidth];
    end
    for (int i = 0; i < 4; i++) begin
      off_c[expWidth*i +: expWidth] = emax_c - in_exp[expWidth*i +: expWidth];
    end
  end

  always_comb begin : fsm_comb
    state_d       = state_q;
    in_ready      = 1'b0;
    sh_exp_offset = '0;
    sh_mantissa   = '0;
    sh_sign       = '0;
    out_valid     = 1'b0;
    out_exp       = '0;
    out_man       = '0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StPass0;
      end
      StPass0: begin
        sh_exp_offset = off_q[2*expWidth-1:0];
        sh_mantissa   = man_q[2*sigWidth-1:0];
        sh_sign       = {1'b0, sign_q[1:0]};
        state_d       = StPass1;
      end
      StPass1: begin
        sh_exp_offset = off_q[4*expWidth-1:2*expWidth];
        sh_mantissa   = man_q[4*sigWidth-1:2*sigWidth];
        sh_sign       = {1'b0, sign_q[3:2]};
        state_d       = StOut;
      end
      StOut: begin
        out_valid = 1'b1;
        out_exp   = emax_q;
        out_man   = slot_q;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? StPass0 : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sign_q  <= '0;
      man_q   <= '0;
      off_q   <= '0;
      emax_q  <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sign_q <= in_sign;
        man_q  <= in_man;
        off_q  <= off_c;
        emax_q <= emax_c;
      end
      // The shifter is combinational, so its result is valid in the same pass cycle.
      if (state_q == StPass0) slot_q[2*W-1:0]   <= sh_man_off;
      if (state_q == StPass1) slot_q[4*W-1:2*W] <= sh_man_off;
    end
  end

endmodule

// File: tb/tb_hadamard_align_sched.sv
// Directed bench for hadamard_align_sched with a behavioural model of the
// external alignment shifter (sign-magnitude, hidden bit and guard zeros).
module tb_hadamard_align_sched;

  localparam int unsigned E  = 3;
  localparam int unsigned S  = 3;
  localparam int unsigned LE = 2;
  localparam int unsigned W  = S + 4 + LE;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_sign;
  logic [4*E-1:0] in_exp;
  logic [4*S-1:0] in_man;
  logic [2*E-1:0] sh_exp_offset;
  logic [2*S-1:0] sh_mantissa;
  logic [2:0]     sh_sign;
  logic [2*W-1:0] sh_man_off;
  logic           out_valid;
  logic           out_ready;
  logic [E-1:0]   out_exp;
  logic [4*W-1:0] out_man;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0]     gs[3];
  logic [4*E-1:0] ge[3];
  logic [4*S-1:0] gm[3];
  logic [4*W-1:0] xm[3];
  logic [E-1:0]   xe[3];

  hadamard_align_sched #(
    .expWidth  (E),
    .sigWidth  (S),
    .low_expand(LE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_man       (in_man),
    .sh_exp_offset(sh_exp_offset),
    .sh_mantissa  (sh_mantissa),
    .sh_sign      (sh_sign),
    .sh_man_off   (sh_man_off),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_exp      (out_exp),
    .out_man      (out_man)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shifter: magnitude {0,0,1,man,00} shifted right by offset, sign in MSB.
  always_comb begin
    logic [W-2:0] mag;
    mag        = '0;
    sh_man_off = '0;
    for (int i = 0; i < 2; i++) begin
      mag = {2'b00, 1'b1, sh_mantissa[S*i +: S], {LE{1'b0}}} >> sh_exp_offset[E*i +: E];
      sh_man_off[W*i +: W] = {sh_sign[i], mag};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, expv);
  endtask

  task automatic drive(input logic [3:0] s, input logic [4*E-1:0] e, input logic [4*S-1:0] m);
    in_sign = s;
    in_exp  = e;
    in_man  = m;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(4'b0, '0, '0);
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_exp", 64'(out_exp), 64'd0);
    check("rst_out_man", 64'(out_man), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sh_off", 64'(sh_exp_offset), 64'd0);
    rst = 1'b0;

    // Equal exponents
    drive(4'b0000, {3'd5, 3'd5, 3'd5, 3'd5}, {4{3'b101}});
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("a_p0_valid", 64'(out_valid), 64'd0);
    check("a_p0_ready", 64'(in_ready), 64'd0);
    check("a_p0_off", 64'(sh_exp_offset), 64'd0);
    check("a_p0_man", 64'(sh_mantissa), 64'b101101);
    check("a_p0_sign", 64'(sh_sign), 64'd0);
    @(negedge clk);
    check("a_p1_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("a_out_valid", 64'(out_valid), 64'd1);
    check("a_out_exp", 64'(out_exp), 64'd5);
    check("a_out_man", 64'(out_man), 64'({4{9'h034}}));
    check("a_out_ready_bp", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    check("a_out_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("a_idle_valid", 64'(out_valid), 64'd0);
    check("a_idle_ready", 64'(in_ready), 64'd1);

    // Mixed exponents, offsets {0,2,5,1}
    out_ready = 1'b0;
    drive(4'b1010, {3'd4, 3'd0, 3'd3, 3'd5}, {4{3'b101}});
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("b_p0_off", 64'(sh_exp_offset), 64'b010_000);
    check("b_p0_sign", 64'(sh_sign), 64'b010);
    check("b_p0_man", 64'(sh_mantissa), 64'b101101);
    @(negedge clk);
    check("b_p1_off", 64'(sh_exp_offset), 64'b001_101);
    check("b_p1_sign", 64'(sh_sign), 64'b010);
    @(negedge clk);
    check("b_out_exp", 64'(out_exp), 64'd5);
    check("b_out_man", 64'(out_man), 64'({9'h11A, 9'h001, 9'h10D, 9'h034}));

    // Backpressure with a pending group that must be ignored until release
    drive(4'b0010, {3'd7, 3'd7, 3'd0, 3'd7}, {4{3'b101}});
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_exp", 64'(out_exp), 64'd5);
      check("bp_man", 64'(out_man), 64'({9'h11A, 9'h001, 9'h10D, 9'h034}));
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    check("c_p0_valid", 64'(out_valid), 64'd0);
    check("c_p0_off", 64'(sh_exp_offset), 64'b111_000);
    check("c_p0_sign", 64'(sh_sign), 64'b010);
    @(negedge clk);
    check("c_p1_off", 64'(sh_exp_offset), 64'd0);
    check("c_p1_sign", 64'(sh_sign), 64'd0);
    @(negedge clk);
    check("c_out_exp", 64'(out_exp), 64'd7);
    check("c_out_man", 64'(out_man), 64'({9'h034, 9'h034, 9'h100, 9'h034}));

    // Back-to-back groups with out_ready held high
    gs[0] = 4'b0000; ge[0] = {3'd2, 3'd2, 3'd2, 3'd2};
    gm[0] = {3'b011, 3'b010, 3'b001, 3'b000};
    xe[0] = 3'd2;    xm[0] = {9'h02C, 9'h028, 9'h024, 9'h020};
    gs[1] = 4'b1001; ge[1] = {3'd1, 3'd6, 3'd4, 3'd6};
    gm[1] = {3'b000, 3'b100, 3'b110, 3'b111};
    xe[1] = 3'd6;    xm[1] = {9'h101, 9'h030, 9'h00E, 9'h13C};
    gs[2] = 4'b0110; ge[2] = {3'd2, 3'd3, 3'd1, 3'd0};
    gm[2] = {3'b111, 3'b001, 3'b101, 3'b011};
    xe[2] = 3'd3;    xm[2] = {9'h01E, 9'h124, 9'h10D, 9'h005};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(gs[0], ge[0], gm[0]);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("b2b_p0_valid", 64'(out_valid), 64'd0);
      if (k < 2) drive(gs[k+1], ge[k+1], gm[k+1]);
      else in_valid = 1'b0;
      @(negedge clk);
      check("b2b_p1_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("b2b_out_valid", 64'(out_valid), 64'd1);
      check("b2b_out_exp", 64'(out_exp), 64'(xe[k]));
      check("b2b_out_man", 64'(out_man), 64'(xm[k]));
    end
    @(negedge clk);
    check("b2b_idle", 64'(in_ready), 64'd1);

    // Reset in PASS1 discards the group
    drive(4'b1010, {3'd4, 3'd0, 3'd3, 3'd5}, {4{3'b101}});
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("r_p1_off", 64'(sh_exp_offset), 64'b001_101);
    rst = 1'b1;
    @(negedge clk);
    check("r_valid", 64'(out_valid), 64'd0);
    check("r_in_ready", 64'(in_ready), 64'd1);
    check("r_sh", 64'({sh_exp_offset, sh_mantissa, sh_sign}), 64'd0);
    check("r_out_man", 64'(out_man), 64'd0);
    rst = 1'b0;
    out_ready = 1'b0;
    drive(gs[1], ge[1], gm[1]);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("r_after_valid", 64'(out_valid), 64'd1);
    check("r_after_exp", 64'(out_exp), 64'd6);
    check("r_after_man", 64'(out_man), 64'(xm[1]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
